// File: rtl/wakeup_broadcast_pipe_if.sv
// Issue-side inputs and wakeup-side outputs of the wakeup broadcast pipe, one entry per lane.
interface wakeup_broadcast_pipe_if #(
    parameter int LANE_NUM     = 2,
    parameter int MAX_LAT      = 4,
    parameter int PREG_BITS    = 7,
    parameter int IQ_ENTRY_NUM = 16
);
    localparam int LAT_BITS = $clog2(MAX_LAT + 1);

    logic [LANE_NUM-1:0]                   issueValid;
    logic [LANE_NUM-1:0][LAT_BITS-1:0]     issueLat;
    logic [LANE_NUM-1:0]                   issueDstValid;
    logic [LANE_NUM-1:0][PREG_BITS-1:0]    issueDstNum;
    logic [LANE_NUM-1:0][IQ_ENTRY_NUM-1:0] issuePtr;
    logic                                  flush;

    logic [LANE_NUM-1:0]                   wakeup;
    logic [LANE_NUM-1:0]                   wakeupDstValid;
    logic [LANE_NUM-1:0][PREG_BITS-1:0]    wakeupDstNum;
    logic [LANE_NUM-1:0][IQ_ENTRY_NUM-1:0] wakeupVector;
    logic [LANE_NUM-1:0][MAX_LAT-1:0]      slotBusy;
    logic                                  collisionErr;

    modport master (
        output issueValid, issueLat, issueDstValid, issueDstNum, issuePtr, flush,
        input  wakeup, wakeupDstValid, wakeupDstNum, wakeupVector, slotBusy, collisionErr
    );

    modport slave (
        input  issueValid, issueLat, issueDstValid, issueDstNum, issuePtr, flush,
        output wakeup, wakeupDstValid, wakeupDstNum, wakeupVector, slotBusy, collisionErr
    );
endinterface

// File: rtl/wakeup_broadcast_pipe.sv
// Purpose: per-lane latency shift pipe that broadcasts producer tags/vectors when results are due.
// Latency: wakeup asserts exactly issueLat cycles after the issue; outputs come straight from registers.
// Backpressure: none; colliding or illegal issues are dropped and flagged, slotBusy lets issue avoid them.
module wakeup_broadcast_pipe #(
    parameter int LANE_NUM     = 2,
    parameter int MAX_LAT      = 4,
    parameter int PREG_BITS    = 7,
    parameter int IQ_ENTRY_NUM = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wakeup_broadcast_pipe_if.slave bus
);
    localparam int LAT_BITS = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic                    vld;
        logic                    dstVld;
        logic [PREG_BITS-1:0]    dstNum;
        logic [IQ_ENTRY_NUM-1:0] ptr;
    } slot_t;

    slot_t slots    [LANE_NUM][MAX_LAT];
    slot_t slotsNxt [LANE_NUM][MAX_LAT];
    logic  errQ;
    logic  errNxt;

    logic [LANE_NUM-1:0][MAX_LAT-1:0] busyVec;
    logic [LANE_NUM-1:0]              latLegal;
    logic [LANE_NUM-1:0]              latBusy;

    // A latency-L issue lands in slot[L-1] after the shift, i.e. where pre-shift slot[L] would go.
    always_comb begin
        busyVec = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            for (int k = 1; k < MAX_LAT; k++) begin
                busyVec[i][k-1] = slots[i][k].vld;
            end
        end
    end

    always_comb begin
        errNxt   = errQ;
        latLegal = '0;
        latBusy  = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
                slotsNxt[i][k] = slots[i][k+1];
            end
            slotsNxt[i][MAX_LAT-1] = '0;

            for (int k = 1; k <= MAX_LAT; k++) begin
                if (bus.issueLat[i] == LAT_BITS'(k)) begin
                    latLegal[i] = 1'b1;
                    latBusy[i]  = busyVec[i][k-1];
                end
            end

            if (bus.issueValid[i] && !bus.flush) begin
                if (!latLegal[i] || latBusy[i]) begin
                    errNxt = 1'b1;
                end else begin
                    for (int k = 1; k <= MAX_LAT; k++) begin
                        if (bus.issueLat[i] == LAT_BITS'(k)) begin
                            slotsNxt[i][k-1].vld    = 1'b1;
                            slotsNxt[i][k-1].dstVld = bus.issueDstValid[i];
                            slotsNxt[i][k-1].dstNum = bus.issueDstNum[i];
                            slotsNxt[i][k-1].ptr    = bus.issuePtr[i];
                        end
                    end
                end
            end

            if (bus.flush) begin
                for (int k = 0; k < MAX_LAT; k++) begin
                    slotsNxt[i][k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LANE_NUM; i++) begin
                for (int k = 0; k < MAX_LAT; k++) begin
                    slots[i][k] <= '0;
                end
            end
            errQ <= 1'b0;
        end else begin
            for (int i = 0; i < LANE_NUM; i++) begin
                for (int k = 0; k < MAX_LAT; k++) begin
                    slots[i][k] <= slotsNxt[i][k];
                end
            end
            errQ <= errNxt;
        end
    end

    // Fields are gated by valid so an idle lane always presents an all-zero broadcast.
    always_comb begin
        for (int i = 0; i < LANE_NUM; i++) begin
            bus.wakeup[i]         = slots[i][0].vld;
            bus.wakeupDstValid[i] = slots[i][0].vld & slots[i][0].dstVld;
            bus.wakeupDstNum[i]   = slots[i][0].vld ? slots[i][0].dstNum : '0;
            bus.wakeupVector[i]   = slots[i][0].vld ? slots[i][0].ptr : '0;
        end
    end

    assign bus.slotBusy     = busyVec;
    assign bus.collisionErr = errQ;
endmodule

// File: tb/tb_wakeup_broadcast_pipe.sv
// Directed bench: issues push expected broadcasts into per-lane queues, a negedge monitor checks them.
module tb_wakeup_broadcast_pipe;
    localparam int LANE_NUM     = 2;
    localparam int MAX_LAT      = 4;
    localparam int PREG_BITS    = 7;
    localparam int IQ_ENTRY_NUM = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wakeup_broadcast_pipe_if #(
        .LANE_NUM(LANE_NUM), .MAX_LAT(MAX_LAT),
        .PREG_BITS(PREG_BITS), .IQ_ENTRY_NUM(IQ_ENTRY_NUM)
    ) bus ();

    wakeup_broadcast_pipe #(
        .LANE_NUM(LANE_NUM), .MAX_LAT(MAX_LAT),
        .PREG_BITS(PREG_BITS), .IQ_ENTRY_NUM(IQ_ENTRY_NUM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int cyc;
        bit dv;
        int dn;
        int vec;
    } exp_t;

    exp_t expQ [LANE_NUM][$];
    int   nChecks = 0;
    int   nFail   = 0;
    bit   monOn   = 1'b0;

    task automatic chk(string name, longint act, longint req);
        nChecks++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic drv(int lane, int lat, bit dv, int dn, int ptr, bit bcast);
        bus.issueValid[lane]    = 1'b1;
        bus.issueLat[lane]      = lat[2:0];
        bus.issueDstValid[lane] = dv;
        bus.issueDstNum[lane]   = dn[PREG_BITS-1:0];
        bus.issuePtr[lane]      = ptr[IQ_ENTRY_NUM-1:0];
        if (bcast) begin
            exp_t e;
            e.cyc = cyc + lat;
            e.dv  = dv;
            e.dn  = dn;
            e.vec = ptr;
            expQ[lane].push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.issueValid = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            for (int l = 0; l < LANE_NUM; l++) begin
                if (bus.wakeup[l]) begin
                    if (expQ[l].size() == 0) begin
                        chk($sformatf("unexpected_wakeup_l%0d", l), bus.wakeup[l], 0);
                    end else begin
                        e = expQ[l].pop_front();
                        chk($sformatf("wakeup_cycle_l%0d", l), cyc, e.cyc);
                        chk($sformatf("wakeup_dstValid_l%0d", l), bus.wakeupDstValid[l], e.dv);
                        chk($sformatf("wakeup_vector_l%0d", l), bus.wakeupVector[l], e.vec);
                        if (e.dv) chk($sformatf("wakeup_dstNum_l%0d", l), bus.wakeupDstNum[l], e.dn);
                    end
                end else begin
                    chk($sformatf("idle_vector_l%0d", l), bus.wakeupVector[l], 0);
                    chk($sformatf("idle_dstValid_l%0d", l), bus.wakeupDstValid[l], 0);
                    if (expQ[l].size() != 0 && expQ[l][0].cyc <= cyc) begin
                        chk($sformatf("missed_wakeup_l%0d", l), bus.wakeup[l], 1);
                        void'(expQ[l].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.issueValid    = '0;
        bus.issueLat      = '0;
        bus.issueDstValid = '0;
        bus.issueDstNum   = '0;
        bus.issuePtr      = '0;
        bus.flush         = 1'b0;
        rst               = 1'b0;

        // Reset state
        idle(2);
        sample();
        chk("rst_wakeup", bus.wakeup, 0);
        chk("rst_dstValid", bus.wakeupDstValid, 0);
        chk("rst_dstNum", bus.wakeupDstNum, 0);
        chk("rst_vector", bus.wakeupVector, 0);
        chk("rst_slotBusy", bus.slotBusy, 0);
        chk("rst_collisionErr", bus.collisionErr, 0);
        monOn = 1'b1;
        rst   = 1'b1;

        // Basic latency-3 broadcast on lane 0
        drv(0, 3, 1'b1, 5, 'h0004, 1'b1);
        tick();
        sample();
        chk("busy_l0_after_L3", bus.slotBusy[0], 4'b0010);
        idle(4);

        // Lane 1 collision: L=4 then L=1 three cycles later
        drv(1, 4, 1'b1, 9, 'h0100, 1'b1);
        idle(3);
        sample();
        chk("busy_l1_before_collision", bus.slotBusy[1], 4'b0001);
        chk("err_before_collision", bus.collisionErr, 0);
        drv(1, 1, 1'b1, 10, 'h0200, 1'b0);
        tick();
        sample();
        chk("err_after_collision", bus.collisionErr, 1);
        idle(3);

        // Flush discards pending and same-cycle issues, keeps the sticky error
        drv(0, 2, 1'b1, 11, 'h0010, 1'b0);
        drv(1, 2, 1'b1, 12, 'h0020, 1'b0);
        tick();
        bus.flush = 1'b1;
        drv(0, 1, 1'b1, 13, 'h0040, 1'b0);
        tick();
        sample();
        chk("flush_wakeup", bus.wakeup, 0);
        chk("flush_err_kept", bus.collisionErr, 1);
        idle(3);

        // One-cycle reset clears the error
        rst = 1'b0;
        tick();
        sample();
        chk("reset_clears_err", bus.collisionErr, 0);
        chk("reset_clears_busy", bus.slotBusy, 0);
        rst = 1'b1;

        // Back-to-back latency-1 issues
        for (int i = 0; i < 5; i++) begin
            drv(0, 1, 1'b1, 20 + i, 1 << i, 1'b1);
            tick();
        end
        idle(2);
        sample();
        chk("b2b_no_err", bus.collisionErr, 0);

        // Destination-less producer still releases its vector
        drv(1, 2, 1'b0, 33, 'h8000, 1'b1);
        idle(4);

        // Lanes are independent
        drv(0, 2, 1'b1, 40, 'h0001, 1'b1);
        drv(1, 2, 1'b1, 41, 'h0002, 1'b1);
        tick();
        drv(0, 4, 1'b1, 42, 'h0004, 1'b1);
        idle(3);
        sample();
        chk("indep_busy_l0", bus.slotBusy[0], 4'b0001);
        chk("indep_busy_l1", bus.slotBusy[1], 4'b0000);
        drv(1, 1, 1'b1, 43, 'h0008, 1'b1);
        tick();
        sample();
        chk("indep_no_err", bus.collisionErr, 0);
        idle(3);

        // Illegal latencies 0 and MAX_LAT+1
        drv(0, 0, 1'b1, 50, 'h0100, 1'b0);
        tick();
        sample();
        chk("lat0_err", bus.collisionErr, 1);
        rst = 1'b0;
        tick();
        sample();
        chk("lat0_err_cleared", bus.collisionErr, 0);
        rst = 1'b1;
        drv(1, MAX_LAT + 1, 1'b1, 51, 'h0200, 1'b0);
        tick();
        sample();
        chk("latmax1_err", bus.collisionErr, 1);
        idle(6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sample();
        chk("latmax1_err_cleared", bus.collisionErr, 0);

        // Reset mid-operation drops pending work and ignores issues during reset
        drv(0, 3, 1'b1, 60, 'h0400, 1'b0);
        tick();
        rst = 1'b0;
        drv(1, 1, 1'b1, 61, 'h0800, 1'b0);
        tick();
        rst = 1'b1;
        sample();
        chk("midrst_wakeup", bus.wakeup, 0);
        chk("midrst_busy", bus.slotBusy, 0);
        idle(5);
        sample();
        chk("midrst_err", bus.collisionErr, 0);

        for (int l = 0; l < LANE_NUM; l++) begin
            chk($sformatf("queue_drained_l%0d", l), expQ[l].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/wakeup_broadcast_pipe.md
WAKEUP_BROADCAST_PIPE -- requirements
Module: wakeup_broadcast_pipe

Interface
REQ-001 SHALL have parameter LANE_NUM, default 2: issue lanes, each with one wakeup broadcast port.
REQ-002 SHALL have parameter MAX_LAT, default 4: maximum execution latency in cycles, at least 1.
REQ-003 SHALL have parameter PREG_BITS, default 7: physical register number width.
REQ-004 SHALL have parameter IQ_ENTRY_NUM, default 16: issue queue entries, which is the wakeup vector width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port issueValid[LANE_NUM], input, 1 bit: an instruction is issued on the lane this cycle.
REQ-008 SHALL have port issueLat[LANE_NUM], input, $clog2(MAX_LAT+1) bits: execution latency.
REQ-009 SHALL have ports issueDstValid and issueDstNum[LANE_NUM], input, 1 bit and PREG_BITS: destination register tag.
REQ-010 SHALL have port issuePtr[LANE_NUM], input, IQ_ENTRY_NUM bits: one-hot issue queue entry of the producer.
REQ-011 SHALL have port flush, input, 1 bit: discard all pending broadcasts.
REQ-012 SHALL have port wakeup[LANE_NUM], output, 1 bit: broadcast valid.
REQ-013 SHALL have ports wakeupDstValid and wakeupDstNum[LANE_NUM], output, 1 bit and PREG_BITS: broadcast register tag.
REQ-014 SHALL have port wakeupVector[LANE_NUM], output, IQ_ENTRY_NUM bits: producer one-hot vector; all zero when wakeup=0.
REQ-015 SHALL have port slotBusy[LANE_NUM], output, MAX_LAT bits: bit L-1 set means issuing with latency L next cycle collides.
REQ-016 SHALL have port collisionErr, output, 1 bit: sticky flag for a dropped issue.

Function
REQ-017 SHALL hold, per lane, a slot array slot[0..MAX_LAT-1]; each slot stores {valid, dstValid, dstNum, ptr}.
REQ-018 SHALL drive wakeup/wakeupDst*/wakeupVector of lane i directly from registered slot[0] of lane i, with no combinational path from inputs.
REQ-019 SHALL shift each cycle: slot[k] <= slot[k+1] for k < MAX_LAT-1; slot[MAX_LAT-1] <= invalid.
REQ-020 SHALL, for an issue with latency L (1..MAX_LAT), write the entry into slot[L-1] after the shift, so wakeup asserts exactly L cycles after the issue cycle.
REQ-021 SHALL detect a collision when the pre-shift slot[L] is valid (only possible for L < MAX_LAT); the existing entry is kept, the new issue is dropped, and collisionErr is set.
REQ-022 SHALL treat issueLat=0 or issueLat>MAX_LAT as illegal: drop the issue and set collisionErr.
REQ-023 SHALL drive slotBusy[i][L-1] = pre-shift slot[L].valid for L < MAX_LAT, and slotBusy[i][MAX_LAT-1] = 0; slotBusy is combinational from state only.
REQ-024 SHALL keep lanes independent: there are no cross-lane collisions or sharing.
REQ-025 SHALL broadcast an entry with issueDstValid=0 with wakeup=1 and wakeupDstValid=0; its vector is still driven, so matrix dependents are released.
REQ-026 SHALL, on flush=1, invalidate every slot of every lane at the next edge; issues presented in the same cycle are discarded; wakeup is 0 the next cycle.
REQ-027 SHALL keep collisionErr set until reset; flush does not clear it.

Reset
REQ-028 SHALL, while rst=0 at a clock edge, invalidate all slots and clear collisionErr; from the next cycle wakeup=0, wakeupDstValid=0, wakeupDstNum=0, wakeupVector=0, slotBusy=0, collisionErr=0.
REQ-029 SHALL, when reset is asserted mid-operation, discard pending broadcasts and ignore issues presented during reset.

Verification
REQ-030 Lane 0 issue with L=3, dst=5, ptr=0x0004 at cycle t -> wakeup[0]=1, wakeupDstNum=5, wakeupVector=0x0004 only at t+3.
REQ-031 Lane 1 issues L=4 at t, then L=1 at t+3 -> wakeups at t+4 (first) and t+4 would collide; slotBusy[1][0]=1 at t+3; the second issue is dropped and collisionErr=1.
REQ-032 Lane 0 issues L=1 every cycle for 5 cycles -> wakeup[0] is high for 5 consecutive cycles starting the cycle after the first issue, with no error.
REQ-033 Issues L=2 on both lanes at t, flush at t+1 -> wakeup stays 0 on both lanes at t+2; collisionErr unchanged.
REQ-034 issueLat=0 and issueLat=MAX_LAT+1 -> never broadcast, collisionErr=1; rst=0 for one cycle clears it to 0.
REQ-035 issueDstValid=0 with L=2 -> wakeup=1, wakeupDstValid=0, vector driven at t+2.
